// File: rtl/spi_pkg.sv
// Shared SPI definitions: sequencer state encoding and default widths.
package spi_pkg;

    localparam int unsigned SPI_DATA_WIDTH_DEF     = 8;
    localparam int unsigned BURST_LENGTH_WIDTH_DEF = 4;
    localparam int unsigned GAP_CYCLES_DEF         = 4;
    localparam int unsigned TIMEOUT_CYCLES_DEF     = 1024;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_LAUNCH    = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_DELIVER   = 3'd4,
        ST_GAP       = 3'd5
    } spi_state_t;

endpackage

// File: rtl/spi_watchdog_counter.sv
// Per-word watchdog: down-counter loaded at launch, expires at terminal count.
// Only built when SPI_BURST_TIMEOUT_EN is defined.
`ifdef SPI_BURST_TIMEOUT_EN
module spi_watchdog_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_load,
    input  logic i_run,
    output logic o_expire
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] count;

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            count <= '0;
        end else if (i_load) begin
            count <= CNT_W'(TIMEOUT_CYCLES - 1);
        end else if (i_run && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign o_expire = i_run && (count == '0);

endmodule
`endif

// File: rtl/spi_burst_sequencer.sv
// Burst sequencer feeding words to an SPI master and returning its replies.
// Optional per-word watchdog enabled by defining SPI_BURST_TIMEOUT_EN.
//
// state        | meaning
// -------------+------------------------------------------------
// ST_IDLE      | waiting for i_start with a non-zero length
// ST_LOAD      | o_tx_ready high, waiting for the next TX word
// ST_LAUNCH    | one-cycle o_spi_enable to the SPI master
// ST_WAIT_DONE | waiting for i_spi_done (watchdog may abort)
// ST_DELIVER   | o_rx_valid high until consumer takes the word
// ST_GAP       | idle spacing before the next word
module spi_burst_sequencer
    import spi_pkg::*;
#(
    parameter int unsigned SPI_DATA_WIDTH     = SPI_DATA_WIDTH_DEF,
    parameter int unsigned BURST_LENGTH_WIDTH = BURST_LENGTH_WIDTH_DEF,
    parameter int unsigned GAP_CYCLES         = GAP_CYCLES_DEF,
    parameter int unsigned TIMEOUT_CYCLES     = TIMEOUT_CYCLES_DEF
) (
    input  logic                          i_clock,
    input  logic                          i_reset_n,
    input  logic                          i_start,
    input  logic [BURST_LENGTH_WIDTH-1:0] i_burst_length,
    input  logic [SPI_DATA_WIDTH-1:0]     i_tx_data,
    input  logic                          i_tx_valid,
    output logic                          o_tx_ready,
    output logic [SPI_DATA_WIDTH-1:0]     o_rx_data,
    output logic                          o_rx_valid,
    input  logic                          i_rx_ready,
    output logic                          o_spi_enable,
    output logic [SPI_DATA_WIDTH-1:0]     o_spi_data_in,
    input  logic [SPI_DATA_WIDTH-1:0]     i_spi_data_out,
    input  logic                          i_spi_done,
    output logic                          o_busy,
    output logic                          o_burst_done,
    output logic                          o_timeout
);

    localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    spi_state_t                    state, state_nxt;
    logic [BURST_LENGTH_WIDTH-1:0] remaining;
    logic [GAP_W-1:0]              gap_cnt;
    logic                          burst_done_q;

    logic start_acc, tx_hs, done_cap, rx_hs, last_word, gap_load, wd_abort;
    logic tx_ready, spi_enable;
    logic wd_expire;

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        tx_ready   = 1'b0;
        spi_enable = 1'b0;
        start_acc  = 1'b0;
        tx_hs      = 1'b0;
        done_cap   = 1'b0;
        rx_hs      = 1'b0;
        last_word  = 1'b0;
        gap_load   = 1'b0;
        wd_abort   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_start && (i_burst_length != '0)) begin
                    start_acc = 1'b1;
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                tx_ready = 1'b1;
                if (i_tx_valid) begin
                    tx_hs     = 1'b1;
                    state_nxt = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                spi_enable = 1'b1;
                state_nxt  = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                // A done arriving on the expiry cycle still wins over the abort.
                if (i_spi_done) begin
                    done_cap  = 1'b1;
                    state_nxt = ST_DELIVER;
                end else if (wd_expire) begin
                    wd_abort  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_DELIVER: begin
                if (i_rx_ready) begin
                    rx_hs = 1'b1;
                    if (remaining == BURST_LENGTH_WIDTH'(1)) begin
                        last_word = 1'b1;
                        state_nxt = ST_IDLE;
                    end else if (GAP_CYCLES > 0) begin
                        gap_load  = 1'b1;
                        state_nxt = ST_GAP;
                    end else begin
                        state_nxt = ST_LOAD;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt == '0) begin
                    state_nxt = ST_LOAD;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            remaining     <= '0;
            gap_cnt       <= '0;
            o_spi_data_in <= '0;
            o_rx_data     <= '0;
            burst_done_q  <= 1'b0;
        end else begin
            if (start_acc) begin
                remaining <= i_burst_length;
            end else if (rx_hs) begin
                remaining <= remaining - 1'b1;
            end
            if (gap_load) begin
                gap_cnt <= GAP_W'(GAP_LOAD);
            end else if ((state == ST_GAP) && (gap_cnt != '0)) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
            if (tx_hs) begin
                o_spi_data_in <= i_tx_data;
            end
            if (done_cap) begin
                o_rx_data <= i_spi_data_out;
            end
            burst_done_q <= last_word;
        end
    end

`ifdef SPI_BURST_TIMEOUT_EN
    logic timeout_q;

    spi_watchdog_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .i_clock  (i_clock),
        .i_reset_n(i_reset_n),
        .i_load   (spi_enable),
        .i_run    (state == ST_WAIT_DONE),
        .o_expire (wd_expire)
    );

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            timeout_q <= 1'b0;
        end else if (start_acc) begin
            timeout_q <= 1'b0;
        end else if (wd_abort) begin
            timeout_q <= 1'b1;
        end
    end

    assign o_timeout = timeout_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign wd_expire          = 1'b0;
    assign o_timeout          = 1'b0;
`endif

    assign o_tx_ready   = tx_ready;
    assign o_spi_enable = spi_enable;
    assign o_rx_valid   = (state == ST_DELIVER);
    assign o_busy       = (state != ST_IDLE);
    assign o_burst_done = burst_done_q;

endmodule
